led_scroll_engine: RTL

- Parametrised successor to the fixed 16-LED, single-pattern scroller.
- Generates a step tick internally from clk_fpga; no separate slow-clock module.
- Supports any LED count, four selectable patterns, mirrored direction, pause, and step/wrap status pulses.
- Drives the board LED bank directly from the top level.

---
 rtl/led_scroll_engine.sv | 89 ++++++++
 1 files changed

// File: rtl/led_scroll_engine.sv
// led_scroll_engine: parametrised LED scroller with internal step divider, four patterns and mirroring.
// Optional PWM dimming of the LED bank is enabled with macro LED_SCROLL_DIM_EN.
module led_scroll_engine #(
  parameter int WIDTH    = 16,
  parameter int CLK_HZ   = 100000000,
  parameter int STEP_HZ  = 10,
  parameter int DIM_DUTY = 8
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             wrap
);
  typedef enum logic [1:0] {DARK_WALK, LIT_WALK, BOUNCE, FILL} mode_t;
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  mode_t            mode_q;
  logic [WIDTH-1:0] pattern, pattern_next, seq_next, start, shl1, oriented;
  logic [DW-1:0]    divider;
  logic             bounce_up, bounce_next, tick, mode_chg, wrap_c, dim_on;
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) rev[i] = v[WIDTH-1-i];
  endfunction
  always_comb begin
    mode_chg = mode != mode_q;
    tick = enable && divider == DW'(DIV - 1);
    start = mode_t'(mode) == DARK_WALK ? ~ONE : mode_t'(mode) == FILL ? '0 : ONE;
    shl1 = {pattern[WIDTH-2:0], 1'b1};
    seq_next = shl1;
    wrap_c = 1'b0;
    bounce_next = bounce_up;
    case (mode_q)
      DARK_WALK: begin
        wrap_c = &pattern;
        seq_next = wrap_c ? ~ONE : shl1;
      end
      LIT_WALK: begin
        wrap_c = ~|pattern;
        seq_next = wrap_c ? ONE : pattern << 1;
      end
      BOUNCE: begin
        // direction flips on the tick that lands on an end bit, so ends are shown once
        seq_next = bounce_up ? pattern << 1 : pattern >> 1;
        bounce_next = bounce_up ? !seq_next[WIDTH-1] : seq_next[0];
        wrap_c = !bounce_up && seq_next[0];
      end
      default: begin
        wrap_c = &pattern;
        seq_next = wrap_c ? '0 : shl1;
      end
    endcase
    pattern_next = mode_chg ? start : tick ? seq_next : pattern;
    oriented = dir ? rev(pattern_next) : pattern_next;
  end
`ifdef LED_SCROLL_DIM_EN
  logic [3:0] pwm_cnt;
  always_ff @(posedge clk_fpga or posedge reset)
    if (reset) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 4'd1;
  assign dim_on = 32'(pwm_cnt) < DIM_DUTY;
`else
  // DIM_DUTY is a non-negative slot count, so the bank is always fully on here
  assign dim_on = DIM_DUTY >= 0;
`endif
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      mode_q <= DARK_WALK;
      pattern <= ~ONE;
      divider <= '0;
      bounce_up <= 1'b1;
      led <= ~ONE;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      mode_q <= mode_t'(mode);
      pattern <= pattern_next;
      divider <= (mode_chg || !enable || tick) ? '0 : divider + DW'(1);
      bounce_up <= mode_chg ? 1'b1 : tick ? bounce_next : bounce_up;
      led <= oriented & {WIDTH{dim_on}};
      step <= tick && !mode_chg;
      wrap <= tick && !mode_chg && wrap_c;
    end
  end
endmodule
